grav_accel_accum: RTL and testbench
===================================

Name: grav_accel_accum

Overview:
- Consumes the per-pair 1/r stream from the pipelined inverse-square-root unit and forms the gravitational acceleration contribution m*d/r^3 per axis.
- Accumulates those contributions over a frame of body pairs and emits one summed (ax, ay, az) per frame.
- Sits directly downstream of the inverse-sqrt unit. dx/dy/dz/mass enter together with that unit's input and are delay-matched internally.
- Uses the team's 32-bit float format, the team's combinational FP multiplier and the team's 2-stage FP adder.

Parameters:
- LAT, 4: cycles from an input to the inverse-sqrt unit until its 1/r appears on iInvR; also the internal delay-line depth.

Ports:
- iCLK  in  1  clock; all state on the rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iValid  in  1  pair term present this cycle; same cycle the pair's r^2 enters the inverse-sqrt unit.
- iLast  in  1  qualifies iValid; marks the final term of the frame.
- iDx, iDy, iDz  in  32 each  float displacement (other minus self).
- iMass  in  32  float mass of other body (G folded in).
- iInvR  in  32  float 1/r from the inverse-sqrt unit; belongs to the input presented LAT cycles earlier.
- oAx, oAy, oAz  out  32 each  float frame sums.
- oValid  out  1  one-cycle pulse; oAx/oAy/oAz valid.
- oBusy  out  1  frame closing; new iValid is not accepted.
- oOverrun  out  1  sticky; iValid arrived while oBusy.

Behaviour:
- Reset (async, iRST_N=0): all outputs 0; delay line, pipeline valids, bank sums, bank select, FSM and oOverrun cleared.
- Reset mid-frame: partial sums are discarded and no oValid is produced.
- Input acceptance: acc = iValid & ~oBusy. iValid while oBusy is dropped and sets oOverrun.
- Delay line: LAT-deep shift register carrying valid, last, dx, dy, dz and mass. Its output aligns with iInvR.
- Stage S1 register (delay output valid): p_r2 = iInvR*iInvR; p_m = mass*iInvR; carry d and last.
- Stage S2 register: s = p_r2*p_m (m/r^3); carry d and last.
- Stage S3: term_x = s*dx (likewise y and z), combinational, fed to the three adders alongside the selected bank's partial sum.
- Ping-pong banks: two partial-sum banks (B0, B1) per axis, reset value 0.
  - Bank select toggles on every S3 term and starts at B0 each frame.
  - Adder result is written back into the same bank 2 cycles later.
  - Consecutive uses of one bank are therefore never closer than 2 cycles, so terms may arrive every cycle with no stall.
- FSM states:
  - ACC: default state.
  - WAIT: entered on the cycle after the last term enters S3, so the final write-back lands.
  - MERGE: per axis, B0+B1 goes into the adder; the result is registered to oAx/oAy/oAz.
  - OUT: oValid=1 for one cycle; then back to ACC.
- Bank clearing: banks are cleared and bank select reset to B0 on the edge that captures the merge result.
- Latency: iValid&iLast accepted in cycle t gives oValid in cycle t+LAT+6.
- oBusy: high from t+1 through t+LAT+6 inclusive. The earliest next-frame term is t+LAT+7.
- oA* hold their value until the next merge capture.
- Zero handling (inherited from the multiplier/adder):
  - A zero-exponent operand makes the term exactly 0.
  - A frame with a single term merges with 0, and the result equals that term.
  - Sums that cancel exactly give 32'h0.
- Arithmetic: no rounding beyond what the multiplier/adder do; no NaN/Inf handling.

Test Plan:
- Single term: iInvR=3f000000, iMass=40000000, iDx=40800000, iDy=iDz=0, iLast=1. Required: oValid exactly LAT+6 cycles later; oAx=3f800000, oAy=oAz=0; oBusy spans LAT+6 cycles.
- Three back-to-back terms, each giving 1.0 on x (same values as above), last on the third. Required: oAx=40400000 (B0=2.0, B1=1.0); exactly one oValid pulse.
- Cancellation: dx=40800000 then dx=c0800000, consecutive cycles, same mass and 1/r. Required: oAx=00000000.
- Overrun: iValid asserted 2 cycles after iLast. Required: that term is ignored, oOverrun=1 and stays high, and oAx is unchanged from the single-term result.
- Reset mid-frame: assert iRST_N=0 after 2 of 4 terms, then release and send a fresh single-term frame. Required: no oValid from the aborted frame; new result 3f800000; oOverrun=0.
- Back-to-back frames: second frame starts exactly LAT+7 cycles after the first iLast. Required: two correct independent results, with no carry-over of sums between frames.

Source files
------------

// File: rtl/grav_accel_accum_if.sv
// Pair-term input bus and frame-sum output bus of the gravitational acceleration accumulator.
interface grav_accel_accum_if;
    logic        iValid;
    logic        iLast;
    logic [31:0] iDx;
    logic [31:0] iDy;
    logic [31:0] iDz;
    logic [31:0] iMass;
    logic [31:0] iInvR;
    logic [31:0] oAx;
    logic [31:0] oAy;
    logic [31:0] oAz;
    logic        oValid;
    logic        oBusy;
    logic        oOverrun;

    modport master (
        output iValid, iLast, iDx, iDy, iDz, iMass, iInvR,
        input  oAx, oAy, oAz, oValid, oBusy, oOverrun
    );

    modport slave (
        input  iValid, iLast, iDx, iDy, iDz, iMass, iInvR,
        output oAx, oAy, oAz, oValid, oBusy, oOverrun
    );
endinterface

// File: rtl/grav_accel_accum.sv
// Gravitational acceleration accumulator: forms m*d/r^3 per axis from the inverse-sqrt
// stream and sums the terms of a frame into one (ax, ay, az) result.
module grav_accel_accum #(
    parameter int unsigned LAT = 4
) (
    input logic               iCLK,
    input logic               iRST_N,
    grav_accel_accum_if.slave bus
);

    localparam int unsigned W   = 32;
    localparam int unsigned NAX = 3;

    typedef enum logic [1:0] {ST_ACC, ST_WAIT, ST_MERGE, ST_OUT} state_t;

    // Adder pipeline payload after operand alignment.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mb;
        logic [23:0] ms;
        logic        sub;
    } align_t;

    // Truncating float multiply; a zero-exponent operand or exponent underflow yields +0.
    function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [47:0]       prod;
        logic signed [9:0] e;
        logic [22:0]       m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return '0;
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            m = prod[46:24];
            e = e + 10'sd1;
        end else begin
            m = prod[45:23];
        end
        if (e <= 10'sd0) return '0;
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Adder stage 1: order operands by magnitude and right-align the smaller mantissa.
    function automatic align_t fp_add_align(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] big;
        logic [W-1:0] sml;
        logic [23:0]  ms;
        logic [7:0]   diff;
        align_t       r;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        ms     = (sml[30:23] == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
        diff   = big[30:23] - sml[30:23];
        r.sign = big[31];
        r.exp  = big[30:23];
        r.mb   = (big[30:23] == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
        r.ms   = (diff >= 8'd24) ? 24'd0 : (ms >> diff);
        r.sub  = big[31] ^ sml[31];
        return r;
    endfunction

    // Adder stage 2: add/subtract and renormalise; exact cancellation yields +0.
    function automatic logic [W-1:0] fp_add_norm(input align_t r);
        logic [24:0]       sum;
        logic [4:0]        lead;
        logic [4:0]        sh;
        logic signed [9:0] e;
        logic [23:0]       nm;
        sum = r.sub ? ({1'b0, r.mb} - {1'b0, r.ms}) : ({1'b0, r.mb} + {1'b0, r.ms});
        if (sum == 25'd0) return '0;
        if (sum[24]) begin
            e = $signed({2'b00, r.exp}) + 10'sd1;
            return {r.sign, e[7:0], sum[23:1]};
        end
        lead = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (sum[i]) lead = 5'(i);
        end
        sh = 5'd23 - lead;
        e  = $signed({2'b00, r.exp}) - $signed({5'b00000, sh});
        if (e <= 10'sd0) return '0;
        nm = sum[23:0] << sh;
        return {r.sign, e[7:0], nm[22:0]};
    endfunction

    logic         w_acc;
    logic         w_merge_go;
    logic         w_merge_cap;
    logic [W-1:0] w_term  [NAX];
    logic [W-1:0] w_add_a [NAX];
    logic [W-1:0] w_add_b [NAX];
    logic [W-1:0] w_sum   [NAX];

    logic         r_dl_vld  [LAT];
    logic         r_dl_last [LAT];
    logic [W-1:0] r_dl_d    [LAT][NAX];
    logic [W-1:0] r_dl_m    [LAT];

    logic         r_s1_vld;
    logic         r_s1_last;
    logic [W-1:0] r_s1_pr2;
    logic [W-1:0] r_s1_pm;
    logic [W-1:0] r_s1_d [NAX];

    logic         r_s2_vld;
    logic         r_s2_last;
    logic [W-1:0] r_s2_s;
    logic [W-1:0] r_s2_d [NAX];

    logic [W-1:0] r_bank [2][NAX];
    logic         r_sel;

    align_t       r_al [NAX];
    logic         r_add_vld;
    logic         r_add_merge;
    logic         r_add_bank;

    logic [W-1:0] r_a [NAX];
    state_t       r_state;
    logic         r_mph;
    logic         r_valid;
    logic         r_busy;
    logic         r_ovr;

    assign w_acc       = bus.iValid & ~r_busy;
    assign w_merge_go  = (r_state == ST_MERGE) && !r_mph;
    assign w_merge_cap = r_add_vld && r_add_merge;

    assign bus.oAx      = r_a[0];
    assign bus.oAy      = r_a[1];
    assign bus.oAz      = r_a[2];
    assign bus.oValid   = r_valid;
    assign bus.oBusy    = r_busy;
    assign bus.oOverrun = r_ovr;

    // Delay line aligning the accepted pair data with its 1/r from the inverse-sqrt unit.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                r_dl_vld[i]  <= 1'b0;
                r_dl_last[i] <= 1'b0;
                r_dl_m[i]    <= '0;
                for (int unsigned k = 0; k < NAX; k++) r_dl_d[i][k] <= '0;
            end
        end else begin
            r_dl_vld[0]  <= w_acc;
            r_dl_last[0] <= w_acc & bus.iLast;
            r_dl_d[0][0] <= bus.iDx;
            r_dl_d[0][1] <= bus.iDy;
            r_dl_d[0][2] <= bus.iDz;
            r_dl_m[0]    <= bus.iMass;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_dl_vld[i]  <= r_dl_vld[i-1];
                r_dl_last[i] <= r_dl_last[i-1];
                r_dl_m[i]    <= r_dl_m[i-1];
                for (int unsigned k = 0; k < NAX; k++) r_dl_d[i][k] <= r_dl_d[i-1][k];
            end
        end
    end

    // S1: 1/r^2 and m/r; S2: m/r^3; displacement and frame marker ride along.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_pr2  <= '0;
            r_s1_pm   <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_s    <= '0;
            for (int unsigned k = 0; k < NAX; k++) begin
                r_s1_d[k] <= '0;
                r_s2_d[k] <= '0;
            end
        end else begin
            r_s1_vld <= r_dl_vld[LAT-1];
            r_s2_vld <= r_s1_vld;
            if (r_dl_vld[LAT-1]) begin
                r_s1_pr2  <= fp_mul(bus.iInvR, bus.iInvR);
                r_s1_pm   <= fp_mul(r_dl_m[LAT-1], bus.iInvR);
                r_s1_last <= r_dl_last[LAT-1];
                for (int unsigned k = 0; k < NAX; k++) r_s1_d[k] <= r_dl_d[LAT-1][k];
            end
            if (r_s1_vld) begin
                r_s2_s    <= fp_mul(r_s1_pr2, r_s1_pm);
                r_s2_last <= r_s1_last;
                for (int unsigned k = 0; k < NAX; k++) r_s2_d[k] <= r_s1_d[k];
            end
        end
    end

    // S3 terms and adder operand selection: a frame term with its bank, or B0+B1 at merge.
    always_comb begin
        for (int unsigned k = 0; k < NAX; k++) begin
            w_term[k]  = fp_mul(r_s2_s, r_s2_d[k]);
            w_add_a[k] = w_merge_go ? r_bank[0][k] : w_term[k];
            w_add_b[k] = w_merge_go ? r_bank[1][k] : r_bank[r_sel][k];
            w_sum[k]   = fp_add_norm(r_al[k]);
        end
    end

    // Adder stage-1 register with the destination tag of the operation in flight.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_add_vld   <= 1'b0;
            r_add_merge <= 1'b0;
            r_add_bank  <= 1'b0;
            for (int unsigned k = 0; k < NAX; k++) r_al[k] <= '0;
        end else begin
            r_add_vld   <= r_s2_vld || w_merge_go;
            r_add_merge <= w_merge_go;
            r_add_bank  <= r_sel;
            for (int unsigned k = 0; k < NAX; k++) r_al[k] <= fp_add_align(w_add_a[k], w_add_b[k]);
        end
    end

    // Ping-pong banks: terms alternate banks so each bank's write-back lands before its next use.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_sel <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < NAX; k++) r_bank[b][k] <= '0;
            end
        end else if (w_merge_cap) begin
            r_sel <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < NAX; k++) r_bank[b][k] <= '0;
            end
        end else begin
            if (r_s2_vld) r_sel <= ~r_sel;
            if (r_add_vld) begin
                for (int unsigned k = 0; k < NAX; k++) r_bank[r_add_bank][k] <= w_sum[k];
            end
        end
    end

    // Frame result registers; held until the next merge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int unsigned k = 0; k < NAX; k++) r_a[k] <= '0;
        end else if (w_merge_cap) begin
            for (int unsigned k = 0; k < NAX; k++) r_a[k] <= w_sum[k];
        end
    end

    // Frame-close sequencing, busy window and sticky overrun flag.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_ACC;
            r_mph   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_ACC: begin
                    if (r_s2_vld && r_s2_last) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_state <= ST_MERGE;
                    r_mph   <= 1'b0;
                end
                ST_MERGE: begin
                    if (!r_mph) begin
                        r_mph <= 1'b1;
                    end else begin
                        r_state <= ST_OUT;
                        r_valid <= 1'b1;
                    end
                end
                ST_OUT: begin
                    r_state <= ST_ACC;
                end
                default: r_state <= ST_ACC;
            endcase
            if (w_acc && bus.iLast) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_OUT) begin
                r_busy <= 1'b0;
            end
            if (bus.iValid && r_busy) r_ovr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grav_accel_accum.sv
// Bench for grav_accel_accum: random and directed frames against an exact integer model.
module tb_grav_accel_accum;

    localparam int LAT     = 4;
    localparam int LATENCY = LAT + 6;
    localparam int NEVER   = 1 << 30;

    typedef struct {
        int          cyc;
        logic [31:0] ax;
        logic [31:0] ay;
        logic [31:0] az;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc = 0;
    logic [31:0] cur_invr;
    logic [31:0] invr_pipe [LAT];

    exp_t        exp_q[$];
    int          acc_x = 0, acc_y = 0, acc_z = 0;
    int          last_t = -1000;
    int          ovr_from = NEVER;
    logic [31:0] held_x = '0, held_y = '0, held_z = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    grav_accel_accum_if bus_if();

    grav_accel_accum #(.LAT(LAT)) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream inverse-sqrt unit: the 1/r presented with a term appears LAT cycles later.
    always @(posedge clk) begin
        invr_pipe[0] <= cur_invr;
        for (int i = 1; i < LAT; i++) invr_pipe[i] <= invr_pipe[i-1];
    end
    assign bus_if.iInvR = invr_pipe[LAT-1];

    // Exact float encoding of v * 2^sc (v small enough to fit the mantissa).
    function automatic logic [31:0] enc(input int v, input int sc);
        int          mag;
        int          p;
        logic [22:0] man;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
        man = 23'((mag << (23 - p)) & 32'h7fffff);
        return {v < 0, 8'(p + sc + 127), man};
    endfunction

    function automatic bit busy_model(input int c);
        return (c >= last_t + 1) && (c <= last_t + LATENCY);
    endfunction

    function automatic int rnd_d();
        return int'($urandom_range(0, 30)) - 15;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, got, want);
        end
    endtask

    // One cycle with a term: d in integer units, mass m, 1/r = 2^e.
    task automatic step(input logic v, input logic l, input int dx, input int dy, input int dz,
                        input int m, input int e);
        int sc;
        bus_if.iValid = v;
        bus_if.iLast  = l;
        bus_if.iDx    = enc(dx, 0);
        bus_if.iDy    = enc(dy, 0);
        bus_if.iDz    = enc(dz, 0);
        bus_if.iMass  = enc(m, 0);
        cur_invr      = enc(1, e);
        if (v) begin
            if (busy_model(cyc)) begin
                if (ovr_from > cyc + 1) ovr_from = cyc + 1;
            end else begin
                sc = m * (1 << (3 * e + 3));
                acc_x += sc * dx;
                acc_y += sc * dy;
                acc_z += sc * dz;
                if (l) begin
                    exp_q.push_back('{cyc + LATENCY, enc(acc_x, -3), enc(acc_y, -3), enc(acc_z, -3)});
                    last_t = cyc;
                    acc_x = 0;
                    acc_y = 0;
                    acc_z = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_idle();
        bus_if.iValid = 1'b0;
        bus_if.iLast  = 1'($urandom_range(0, 1));
        bus_if.iDx    = $urandom;
        bus_if.iDy    = $urandom;
        bus_if.iDz    = $urandom;
        bus_if.iMass  = $urandom;
        cur_invr      = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            step_idle();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) step_idle();
    endtask

    task automatic reset_now();
        bus_if.iValid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        acc_x = 0;
        acc_y = 0;
        acc_z = 0;
        last_t = -1000;
        ovr_from = NEVER;
        held_x = '0;
        held_y = '0;
        held_z = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each oValid and checks all outputs every cycle.
    always @(negedge clk) begin
        exp_t ex;
        if (bus_if.oValid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ovalid (cycle %0d): got oValid=1, want 0", cyc);
            end else begin
                ex = exp_q.pop_front();
                check("ovalid_cycle", 32'(cyc), 32'(ex.cyc));
                held_x = ex.ax;
                held_y = ex.ay;
                held_z = ex.az;
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_ovalid: got no pulse by cycle %0d, want one at cycle %0d", cyc, exp_q[0].cyc);
            ex = exp_q.pop_front();
            held_x = ex.ax;
            held_y = ex.ay;
            held_z = ex.az;
        end
        check("oAx", bus_if.oAx, held_x);
        check("oAy", bus_if.oAy, held_y);
        check("oAz", bus_if.oAz, held_z);
        check("oBusy", 32'(bus_if.oBusy), 32'(busy_model(cyc)));
        check("oOverrun", 32'(bus_if.oOverrun), 32'(cyc >= ovr_from));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got cycle %0d without finishing, want finish", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        bus_if.iValid = 1'b0;
        bus_if.iLast  = 1'b0;
        bus_if.iDx    = '0;
        bus_if.iDy    = '0;
        bus_if.iDz    = '0;
        bus_if.iMass  = '0;
        cur_invr      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step_idle();

        // Single term: 2 * 4 * 0.5^3 = 1.0 on x.
        step(1, 1, 4, 0, 0, 2, -1);
        wait_drain();

        // Three back-to-back terms: B0 = 2.0, B1 = 1.0, merged 3.0.
        step(1, 0, 4, 0, 0, 2, -1);
        step(1, 0, 4, 0, 0, 2, -1);
        step(1, 1, 4, 0, 0, 2, -1);
        wait_drain();

        // Exact cancellation across banks.
        step(1, 0, 4, 0, 0, 2, -1);
        step(1, 1, -4, 0, 0, 2, -1);
        wait_drain();

        // Overrun: term two cycles after the last is dropped; next frame is unaffected.
        step(1, 1, 4, 0, 0, 2, -1);
        step_idle();
        step(1, 0, 7, 1, 1, 3, 0);
        wait_drain();
        step(1, 1, 2, 0, 0, 2, -1);
        wait_drain();

        // Reset mid-frame, then a fresh single-term frame.
        step(1, 0, 4, 3, 0, 2, -1);
        step(1, 0, 4, 0, 5, 2, -1);
        reset_now();
        repeat (2) step_idle();
        step(1, 1, 4, 0, 0, 2, -1);
        wait_drain();

        // Back-to-back frames at the earliest legal spacing.
        step(1, 1, 4, 0, 0, 2, -1);
        repeat (LATENCY) step_idle();
        step(1, 0, 3, 5, -2, 1, 0);
        step(1, 1, -1, 2, 6, 3, 1);
        wait_drain();

        // Random frames with random gaps, lengths and values.
        for (int f = 0; f < 40; f++) begin
            while (busy_model(cyc)) step_idle();
            repeat ($urandom_range(0, 2)) step_idle();
            n = int'($urandom_range(1, 6));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 4) == 0) step_idle();
                step(1, j == n - 1, rnd_d(), rnd_d(), rnd_d(), int'($urandom_range(1, 7)),
                     int'($urandom_range(0, 2)) - 1);
            end
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
